// File: rtl/pc_seq_pkg.sv
// Package shared by the PC sequencer files.
//   pc_state_t : sequencer FSM states (BOOT, RUN, REDIRECT, HALT)
//   PC_INC     : byte increment between sequential fetches
//   ALU_*      : control codes of the datapath ALU
//   alu64      : the datapath ALU, reused for the PC+4 add so that the
//                sequential-PC adder and the execute adder stay identical.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } pc_state_t;

    localparam int unsigned PC_INC = 4;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    function automatic logic [63:0] alu64(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [2:0]  cntrl);
        logic [63:0] r;
        case (cntrl)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : clock, all state on posedge
//   clear_i : synchronous clear to zero (has priority over inc_i)
//   inc_i   : count up by one; holds once the count is all-ones
//   cnt_o   : current count
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer for the 5-stage pipeline: PC+4, branch redirect,
// stall hold and halt.
// Optional feature macro: PC_DELAY_SLOT_EN (one architectural delay slot;
// flush_id_o is then never asserted).
//   clk           : clock, all state on posedge
//   reset         : synchronous, active-low
//   stall_i       : hazard unit hold
//   br_valid_i    : branch resolved in EX this cycle
//   br_taken_i    : resolved branch taken (qualified by br_valid_i)
//   br_target_i   : branch-target adder output
//   halt_req_i    : stop fetching
//   imem_ready_i  : instruction memory accepts the fetch
//   pc_o          : registered fetch PC
//   fetch_valid_o : pc_o is a valid fetch request
//   flush_if_o    : kill IF/ID contents (combinational, redirect cycle)
//   flush_id_o    : kill ID/EX contents (combinational, redirect cycle)
//   align_err_o   : sticky misaligned taken target
//   br_cnt_o      : saturating count of taken redirects
//   state_o       : FSM state, for debug/observation
//
// Fetch handshake: a fetch of pc_o transfers in a cycle where
// fetch_valid_o && imem_ready_i. While fetch_valid_o is high and the
// transfer has not happened, pc_o stays stable and fetch_valid_o stays high;
// only a taken branch, halt or reset may withdraw the request.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [PC_W-1:0]  br_target_i,
    input  logic             halt_req_i,
    input  logic             imem_ready_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_valid_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             align_err_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output pc_state_t        state_o
);

`ifdef PC_DELAY_SLOT_EN
    // The instruction behind the branch is architecturally executed.
    localparam logic FLUSH_ID_ON_TAKEN = 1'b0;
`else
    localparam logic FLUSH_ID_ON_TAKEN = 1'b1;
`endif

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            align_err_q, align_err_d;
    logic            cnt_inc;
    logic            br_taken;
    logic            br_misaligned;
    logic [PC_W-1:0] pc_inc;

    assign br_taken      = br_valid_i & br_taken_i;
    assign br_misaligned = (br_target_i[1:0] != 2'b00);
    // Sequential PC goes through the same adder as the execute stage.
    assign pc_inc        = PC_W'(alu64(64'(pc_q), 64'(PC_INC), ALU_ADD));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        align_err_d   = align_err_q;
        cnt_inc       = 1'b0;
        fetch_valid_o = 1'b0;
        flush_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                fetch_valid_o = 1'b1;
                if (br_taken) begin
                    // Taken branch overrides stall, memory back-pressure and halt.
                    flush_if_o = 1'b1;
                    flush_id_o = FLUSH_ID_ON_TAKEN;
                    if (br_misaligned) begin
                        align_err_d = 1'b1;
                        state_d     = HALT;
                    end else begin
                        pc_d    = br_target_i;
                        cnt_inc = 1'b1;
                        state_d = REDIRECT;
                    end
                end else if (halt_req_i) begin
                    state_d = HALT;
                end else if (stall_i || !imem_ready_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_inc;
                end
            end
            REDIRECT: begin
                // Bubble cycle; a branch here is a flushed instruction.
                state_d = halt_req_i ? HALT : RUN;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            align_err_q <= align_err_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_br_cnt (
        .clk    (clk),
        .clear_i(!reset),
        .inc_i  (cnt_inc),
        .cnt_o  (br_cnt_o)
    );

    assign pc_o        = pc_q;
    assign align_err_o = align_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. A default instance and a CNT_W=2 instance
// share all inputs; the second one exercises counter saturation.
// Build with PC_DELAY_SLOT_EN defined to check the delay-slot flush variant.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

`ifdef PC_DELAY_SLOT_EN
    localparam logic EXP_FLUSH_ID = 1'b0;
`else
    localparam logic EXP_FLUSH_ID = 1'b1;
`endif

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [63:0] br_target_i;
    logic        halt_req_i;
    logic        imem_ready_i;

    logic [63:0] pc_o;
    logic        fetch_valid_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        align_err_o;
    logic [31:0] br_cnt_o;
    pc_state_t   state_o;

    logic [63:0] s_pc_o;
    logic        s_fetch_valid_o;
    logic        s_flush_if_o;
    logic        s_flush_id_o;
    logic        s_align_err_o;
    logic [1:0]  s_br_cnt_o;
    pc_state_t   s_state_o;

    int n_checks;
    int n_errors;
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i), .halt_req_i(halt_req_i),
        .imem_ready_i(imem_ready_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
        .flush_if_o(flush_if_o), .flush_id_o(flush_id_o), .align_err_o(align_err_o),
        .br_cnt_o(br_cnt_o), .state_o(state_o)
    );

    pc_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i), .halt_req_i(halt_req_i),
        .imem_ready_i(imem_ready_i), .pc_o(s_pc_o), .fetch_valid_o(s_fetch_valid_o),
        .flush_if_o(s_flush_if_o), .flush_id_o(s_flush_id_o), .align_err_o(s_align_err_o),
        .br_cnt_o(s_br_cnt_o), .state_o(s_state_o)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic valid, input logic taken, input logic [63:0] tgt);
        br_valid_i  = valid;
        br_taken_i  = taken;
        br_target_i = tgt;
        #1;
    endtask

    task automatic check_run(input string tag, input logic [63:0] pc);
        check_eq({tag, "_pc"}, pc_o, pc);
        check_eq({tag, "_fv"}, 64'(fetch_valid_o), 64'd1);
        check_eq({tag, "_st"}, 64'(state_o), 64'(RUN));
    endtask

    task automatic check_flush(input string tag, input logic fi, input logic fd);
        check_eq({tag, "_flush_if"}, 64'(flush_if_o), 64'(fi));
        check_eq({tag, "_flush_id"}, 64'(flush_id_o), 64'(fd));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b0;
        stall_i      = 1'b0;
        br_valid_i   = 1'b0;
        br_taken_i   = 1'b0;
        br_target_i  = '0;
        halt_req_i   = 1'b0;
        imem_ready_i = 1'b1;

        // Reset held for two edges.
        step();
        step();
        check_eq("rst_pc", pc_o, 64'h0);
        check_eq("rst_fv", 64'(fetch_valid_o), 64'd0);
        check_eq("rst_st", 64'(state_o), 64'(BOOT));
        check_eq("rst_align", 64'(align_err_o), 64'd0);
        check_eq("rst_cnt", 64'(br_cnt_o), 64'd0);
        check_flush("rst", 1'b0, 1'b0);

        // BOOT -> RUN, then sequential fetch 0,4,8,C,10.
        reset = 1'b1;
        #1;
        check_eq("boot_fv", 64'(fetch_valid_o), 64'd0);
        step();
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        exp_q.push_back(64'hC);
        exp_q.push_back(64'h10);
        while (exp_q.size() > 0) begin
            check_run("seq", exp_q.pop_front());
            check_flush("seq", 1'b0, 1'b0);
            if (exp_q.size() > 0) step();
        end

        // Taken branch at 0x10 to 0x40.
        set_branch(1'b1, 1'b1, 64'h40);
        check_flush("br40", 1'b1, EXP_FLUSH_ID);
        step();
        // Bubble; a branch seen here must be ignored.
        set_branch(1'b1, 1'b1, 64'h80);
        check_eq("br40_bub_pc", pc_o, 64'h40);
        check_eq("br40_bub_fv", 64'(fetch_valid_o), 64'd0);
        check_eq("br40_bub_st", 64'(state_o), 64'(REDIRECT));
        check_eq("br40_cnt", 64'(br_cnt_o), 64'd1);
        check_flush("br40_bub", 1'b0, 1'b0);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_run("br40_run", 64'h40);
        check_eq("br40_cnt2", 64'(br_cnt_o), 64'd1);

        // Not-taken branch has no effect.
        set_branch(1'b1, 1'b0, 64'h100);
        check_flush("nt", 1'b0, 1'b0);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_run("nt", 64'h44);

        // Redirect to 0x20, then stall three cycles.
        set_branch(1'b1, 1'b1, 64'h20);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_eq("br20_cnt", 64'(br_cnt_o), 64'd2);
        step();
        check_run("br20", 64'h20);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_run("stall", 64'h20);
        end
        stall_i      = 1'b0;
        imem_ready_i = 1'b0;
        step();
        check_run("nrdy", 64'h20);

        // Taken branch while stalled and memory not ready still redirects.
        stall_i = 1'b1;
        set_branch(1'b1, 1'b1, 64'h60);
        check_flush("brst", 1'b1, EXP_FLUSH_ID);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        stall_i      = 1'b0;
        imem_ready_i = 1'b1;
        check_eq("brst_pc", pc_o, 64'h60);
        check_eq("brst_cnt", 64'(br_cnt_o), 64'd3);
        check_eq("sat_cnt3", 64'(s_br_cnt_o), 64'd3);
        step();
        check_run("brst_run", 64'h60);
        step();
        check_run("brst_adv", 64'h64);

        // Branch to the top of the address space, then wrap to 0.
        set_branch(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_eq("wrap_cnt", 64'(br_cnt_o), 64'd4);
        check_eq("sat_cnt4", 64'(s_br_cnt_o), 64'd3);
        step();
        check_run("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check_run("wrap_zero", 64'h0);

        // Halt request together with a taken branch: redirect, then HALT.
        halt_req_i = 1'b1;
        set_branch(1'b1, 1'b1, 64'h80);
        check_flush("hbr", 1'b1, EXP_FLUSH_ID);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_eq("hbr_st", 64'(state_o), 64'(REDIRECT));
        check_eq("hbr_pc", pc_o, 64'h80);
        check_eq("hbr_cnt", 64'(br_cnt_o), 64'd5);
        check_eq("sat_cnt5", 64'(s_br_cnt_o), 64'd3);
        step();
        halt_req_i = 1'b0;
        check_eq("halt_st", 64'(state_o), 64'(HALT));
        check_eq("halt_pc", pc_o, 64'h80);
        check_eq("halt_fv", 64'(fetch_valid_o), 64'd0);
        set_branch(1'b1, 1'b1, 64'h100);
        check_flush("halt", 1'b0, 1'b0);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_eq("halt2_st", 64'(state_o), 64'(HALT));
        check_eq("halt2_pc", pc_o, 64'h80);

        // Reset leaves HALT and clears the counters.
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rst2_st", 64'(state_o), 64'(BOOT));
        check_eq("rst2_pc", pc_o, 64'h0);
        check_eq("rst2_cnt", 64'(br_cnt_o), 64'd0);
        check_eq("rst2_sat", 64'(s_br_cnt_o), 64'd0);
        step();
        check_run("rst2_run", 64'h0);
        step();
        check_run("rst2_adv", 64'h4);

        // Misaligned taken target: sticky error, HALT, PC frozen.
        set_branch(1'b1, 1'b1, 64'h42);
        check_flush("mis", 1'b1, EXP_FLUSH_ID);
        step();
        set_branch(1'b0, 1'b0, 64'h0);
        check_eq("mis_align", 64'(align_err_o), 64'd1);
        check_eq("mis_st", 64'(state_o), 64'(HALT));
        check_eq("mis_pc", pc_o, 64'h4);
        check_eq("mis_fv", 64'(fetch_valid_o), 64'd0);
        check_eq("mis_cnt", 64'(br_cnt_o), 64'd0);
        step();
        check_eq("mis2_align", 64'(align_err_o), 64'd1);
        check_eq("mis2_pc", pc_o, 64'h4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("mis_rst_align", 64'(align_err_o), 64'd0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
